// File: rtl/mult_pkg.sv
// Shared constants and encodings for the sequential radix-2 Booth multiplier.
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  // Encoding 2'd3 is unused and falls back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Booth recoding of {L[0], q}.
  typedef enum logic [1:0] {
    PAIR_NOP0 = 2'b00,
    PAIR_ADD  = 2'b01,
    PAIR_SUB  = 2'b10,
    PAIR_NOP1 = 2'b11
  } booth_pair_e;

endpackage

// File: rtl/booth_addsub_32.sv
// 32-bit add/subtract (s = u + m or u - m) built from two 16-bit carry-select halves.
module booth_addsub_32
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] m,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [16:0]      lo_sum;
  logic [15:0]      hi_c0;
  logic [15:0]      hi_c1;
  logic [15:0]      hi_sum;

  always_comb begin
    b_eff  = sub ? ~m : m;
    lo_sum = {1'b0, u[15:0]} + {1'b0, b_eff[15:0]} + {16'd0, sub};
    // Upper half precomputed for both carry-ins; the low carry only drives the select.
    hi_c0  = u[31:16] + b_eff[31:16];
    hi_c1  = u[31:16] + b_eff[31:16] + 16'd1;
    hi_sum = lo_sum[16] ? hi_c1 : hi_c0;
    s      = {hi_sum, lo_sum[15:0]};
    overflow = (u[31] == b_eff[31]) && (s[31] != u[31]);
  end

endmodule

// File: rtl/booth_mult_32.sv
// Sequential 32x32 signed radix-2 Booth multiplier: one add/sub + arithmetic shift per cycle.
module booth_mult_32
  import mult_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] l_q, l_d;
  logic             q_q, q_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  booth_pair_e      pair;
  logic             add_en;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] s_eff;
  logic             sign;
  logic [WIDTH-1:0] u_shift;
  logic [WIDTH-1:0] l_shift;
  logic             fits;

  booth_addsub_32 u_addsub (
    .u        (u_q),
    .m        (m_q),
    .sub      (sub),
    .s        (sum),
    .overflow (ovf)
  );

  always_comb begin
    pair   = booth_pair_e'({l_q[0], q_q});
    add_en = (pair == PAIR_ADD) || (pair == PAIR_SUB);
    sub    = (pair == PAIR_SUB);
    s_eff  = add_en ? sum : u_q;
    // Sign recovered from overflow lets a 32-bit U handle M = 0x80000000.
    sign    = add_en ? (sum[31] ^ ovf) : u_q[31];
    u_shift = {sign, s_eff[31:1]};
    l_shift = {s_eff[0], l_q[31:1]};
    fits    = (u_shift == {WIDTH{l_shift[31]}});
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    u_d      = u_q;
    l_d      = l_q;
    q_d      = q_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (ctrl_MULT) begin
          state_d = ST_RUN;
          m_d     = data_operandA;
          u_d     = '0;
          l_d     = data_operandB;
          q_d     = 1'b0;
          count_d = '0;
        end
      end
      ST_RUN: begin
        u_d     = u_shift;
        l_d     = l_shift;
        q_d     = l_q[0];
        count_d = count_q + 6'd1;
        if (count_q == CNT_W'(ITERS - 1)) begin
          state_d  = ST_DONE;
          result_d = l_shift;
          exc_d    = ~fits;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      u_q      <= '0;
      l_q      <= '0;
      q_q      <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      u_q      <= u_d;
      l_q      <= l_d;
      q_q      <= q_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q == ST_RUN);

endmodule

// File: tb/tb_booth_mult_32.sv
// Directed-vector bench for booth_mult_32 with a queue-based scoreboard and independent monitor.
module tb_booth_mult_32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Scoreboard: {exception, result} and the cycle the ready pulse must be seen in.
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  vec_t        vecs[$];

  booth_mult_32 dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: called on a falling edge; start is sampled on the next rising edge.
  task automatic start_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input bit expect_it, input logic [31:0] r, input logic e);
    data_operandA = op_a;
    data_operandB = op_b;
    ctrl_MULT     = 1'b1;
    if (expect_it) begin
      exp_q.push_back({e, r});
      exp_cyc_q.push_back(cyc + 33);
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results pending, expected 0", name, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!data_resultRDY && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!data_resultRDY) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: ready 0 after %0d cycles, expected 1", name, n);
    end
  endtask

  // Monitor
  logic        prev_rdy = 1'b0;
  logic [32:0] mon_exp;
  int          mon_cyc;

  always @(negedge clock) begin
    if (data_resultRDY) begin
      check("rdy_single_cycle", 64'(prev_rdy), 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rdy: result 0x%0h with no operation pending, expected no pulse",
                 data_result);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("result_exc", 64'({data_exception, data_result}), 64'(mon_exp));
        check("rdy_cycle", 64'(cyc), 64'(mon_cyc));
      end
    end
    prev_rdy = data_resultRDY;
  end

  initial begin
    vecs.push_back('{32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 1'b0});
    vecs.push_back('{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0});
    vecs.push_back('{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1});
    vecs.push_back('{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_B505, 32'h0000_B505, 32'h8000_1219, 1'b1});
    vecs.push_back('{32'hFFFF_4AFB, 32'h0000_B505, 32'h7FFF_EDE7, 1'b1});
    vecs.push_back('{32'h0001_0000, 32'hFFFF_8000, 32'h8000_0000, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1});

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_busy", 64'(busy), 64'd0);

    // Directed vectors
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].exc);
      check("busy_in_run", 64'(busy), 64'd1);
      wait_drain("vector");
    end

    // Start request mid-run is ignored
    start_op(32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 32'hFFFF_FFD6, 1'b0);
    repeat (8) @(negedge clock);
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    wait_drain("ignore_start");
    repeat (40) @(negedge clock);

    // Back-to-back: restart accepted while in DONE
    start_op(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0);
    wait_rdy("b2b_first");
    start_op(32'h0000_B505, 32'h0000_B505, 1'b1, 32'h8000_1219, 1'b1);
    wait_drain("b2b_second");

    // Asynchronous reset mid-run
    start_op(32'h1234_5678, 32'h0000_0009, 1'b0, 32'h0, 1'b0);
    repeat (14) @(negedge clock);
    check("busy_before_reset", 64'(busy), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_result", 64'(data_result), 64'd0);
    check("async_reset_exc", 64'(data_exception), 64'd0);
    check("async_reset_rdy", 64'(data_resultRDY), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (40) @(negedge clock);
    check("post_reset_idle_result", 64'(data_result), 64'd0);
    check("post_reset_idle_busy", 64'(busy), 64'd0);
    start_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 32'hFFFF_FFF1, 1'b0);
    wait_drain("post_reset");

    repeat (5) @(negedge clock);
    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
